// File: rtl/reg_file_2w2r.sv
// Two-write, two-read register file with a per-register pending (busy) scoreboard.
// Reads are registered (one-cycle latency) with optional same-cycle write forwarding.
module reg_file_2w2r #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] sel_A,
  input  logic [ADDR_W-1:0] sel_B,
  output logic [DATA_W-1:0] out_A,
  output logic [DATA_W-1:0] out_B,
  output logic              rd_valid,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              busy_A,
  output logic              busy_B
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d, busy_clr;
  logic [DATA_W-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
  logic              busy_a_q, busy_a_d, busy_b_q, busy_b_d;
  logic              rd_valid_q, rd_valid_d;

  // Next register contents and scoreboard: wr1 overrides wr0, reserve overrides write-clear.
  always_comb begin
    regs_d = regs_q;
    if (wr0_en) regs_d[wr0_addr] = wr0_data;
    if (wr1_en) regs_d[wr1_addr] = wr1_data;
    if (ZERO_REG != 0) regs_d[0] = '0;

    busy_clr = busy_q;
    if (wr0_en) busy_clr[wr0_addr] = 1'b0;
    if (wr1_en) busy_clr[wr1_addr] = 1'b0;
    busy_d = busy_clr;
    if (rsv_en) busy_d[rsv_addr] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  // Read path: forwarded view (post-write) when bypassing, stored view otherwise; hold when idle.
  always_comb begin
    out_a_d    = out_a_q;
    out_b_d    = out_b_q;
    busy_a_d   = busy_a_q;
    busy_b_d   = busy_b_q;
    rd_valid_d = 1'b0;
    if (rd_en) begin
      rd_valid_d = 1'b1;
      if (BYPASS != 0) begin
        out_a_d  = regs_d[sel_A];
        out_b_d  = regs_d[sel_B];
        busy_a_d = busy_clr[sel_A];
        busy_b_d = busy_clr[sel_B];
      end else begin
        out_a_d  = regs_q[sel_A];
        out_b_d  = regs_q[sel_B];
        busy_a_d = busy_q[sel_A];
        busy_b_d = busy_q[sel_B];
      end
      if ((ZERO_REG != 0) && (sel_A == '0)) begin
        out_a_d  = '0;
        busy_a_d = 1'b0;
      end
      if ((ZERO_REG != 0) && (sel_B == '0)) begin
        out_b_d  = '0;
        busy_b_d = 1'b0;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q     <= '0;
      out_a_q    <= '0;
      out_b_q    <= '0;
      busy_a_q   <= 1'b0;
      busy_b_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      out_a_q    <= out_a_d;
      out_b_q    <= out_b_d;
      busy_a_q   <= busy_a_d;
      busy_b_q   <= busy_b_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign out_A    = out_a_q;
  assign out_B    = out_b_q;
  assign busy_A   = busy_a_q;
  assign busy_B   = busy_b_q;
  assign rd_valid = rd_valid_q;

endmodule
